mesi_snoop_bus_arbiter: RTL and testbench
=========================================

Name: mesi_snoop_bus_arbiter

Overview:
- Shared snooping-bus controller for N_CACHES MESI cache controllers.
- Accepts bus-transaction requests (BusRd, BusRdX, BusUpgr) from each cache and grants the bus to one requester at a time, round-robin.
- Broadcasts the winning transaction to all snoopers, collects shared (C) and flush responses, and falls back to memory when no cache supplies the line.
- Returns the C indication and a completion pulse to the requester.

Parameters:
- N_CACHES, 4, number of attached cache controllers (2..16).
- TIMEOUT_CYCLES, 64, memory-ack watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstb  in  1  reset, asynchronous, active-low.
- req  in  N_CACHES  per-cache bus request; held high until the matching done pulse.
- req_cmd  in  2*N_CACHES  per-cache command, slice i = [2i+1:2i]: 01 BusRd, 10 BusRdX, 11 BusUpgr, 00 none.
- gnt  out  N_CACHES  one-hot grant; high from GRANT through DONE.
- done  out  N_CACHES  one-cycle completion pulse to the winner.
- c_out  out  1  shared indication to the winner; valid only while done is high.
- snoop_valid  out  1  one-cycle broadcast strobe.
- snoop_cmd  out  2  broadcast command; held from GRANT to DONE.
- snoop_src  out  N_CACHES  one-hot winner id; held from GRANT to DONE.
- snoop_shared_in  in  N_CACHES  per-cache "line present" response; sampled in RESP.
- snoop_flush_in  in  N_CACHES  per-cache "flushing M copy" response; sampled in RESP.
- mem_req  out  1  memory fetch request; level signal.
- mem_ack  in  1  memory completion; single-cycle pulse.
- err  out  1  timeout error pulse; optional feature only, otherwise tied 0.

Behaviour:
- Reset (rstb low, asynchronous):
  - state = IDLE, rr_ptr = 0.
  - All outputs 0: gnt, done, c_out, snoop_valid, snoop_cmd, snoop_src, mem_req, err.
  - Reset mid-transaction abandons the transaction silently; no done pulse is issued.
- Eligibility: cache i is eligible when req[i]=1 and req_cmd slice i != 00. A request with cmd 00 is never granted.
- States:
  - IDLE: if any cache is eligible, choose the first eligible index at or after rr_ptr, scanning upward with wrap from N_CACHES-1 to 0. Latch winner and cmd, then go to GRANT. Otherwise stay in IDLE.
  - GRANT (1 cycle): gnt[winner]=1, snoop_valid=1, snoop_cmd and snoop_src driven. Go to RESP.
  - RESP (1 cycle):
    - Compute shared = OR(snoop_shared_in & ~snoop_src) and flush = OR(snoop_flush_in & ~snoop_src); the winner's own responses are masked.
    - Latch shared into c_reg.
    - Next state: cmd = BusUpgr -> DONE; flush = 1 -> DONE (data supplied by the flushing cache); otherwise -> MEM.
  - MEM: mem_req=1 until mem_ack is sampled high; mem_req deasserts in the same cycle the state moves to DONE. If mem_ack arrives on the first MEM cycle, MEM lasts exactly 1 cycle.
  - DONE (1 cycle): done[winner]=1, c_out=c_reg (forced 0 for BusRdX and BusUpgr). rr_ptr = winner+1, wrapping to 0 after N_CACHES-1. Go to IDLE.
- Latency from an eligible req sampled in IDLE to the done pulse:
  - 3 cycles for BusUpgr or a flush hit (IDLE→GRANT→RESP→DONE).
  - 3 + k cycles for a memory fetch, where k ≥ 1 is the number of MEM cycles.
  - Minimum one IDLE cycle between back-to-back transactions.
- Inputs ignored mid-transaction:
  - req or req_cmd changes after the latch in IDLE have no effect on the current transaction.
  - A winner dropping req before done still receives done.
- mem_ack outside MEM is ignored.
- Multiple simultaneous flushers: OR-ed; no error.
- N_CACHES = 1: the single cache always wins and all snoop responses are masked, so c_out = 0 and every non-Upgr transaction goes to MEM.

Optional Feature:
- Macro: MESI_ARB_MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on MEM entry and increments each MEM cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES, the arbiter goes to DONE with err=1 coincident with done, c_out=0, and mem_req dropped.
  - A later stray mem_ack is ignored.
- Undefined: no counter; MEM waits indefinitely; err tied 0.

Test Plan:
- Reset, then cache 2 requests BusRd with no shared/flush and mem_ack 2 cycles after MEM entry -> gnt=0100, one snoop_valid pulse with snoop_cmd=01 and snoop_src=0100, mem_req high 2 cycles, done=0100 at cycle 5, c_out=0.
- Caches 0, 1 and 3 request simultaneously with rr_ptr=0 -> grant order 0, 1, 3; each done before the next gnt; rr_ptr ends at 0 (wrap).
- Cache 1 BusRd with snoop_shared_in=1011 in RESP -> c_out=1, MEM path taken. Repeat with shared=0010 (own bit only) -> c_out=0.
- Cache 0 BusRdX with snoop_flush_in=0100 -> no mem_req, done at cycle 3, c_out=0.
- Cache 3 BusUpgr -> done at cycle 3 regardless of responses. Cache 1 with req_cmd=00 -> never granted.
- Assert rstb low during MEM -> mem_req and gnt drop immediately (async), no done. With MESI_ARB_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8 and no mem_ack -> err and done after 8 MEM cycles.

Source files
------------

// File: rtl/mesi_snoop_bus_arbiter.sv
// Round-robin snooping-bus arbiter for MESI caches: grant, broadcast, collect C/flush, memory fallback.
// Optional memory-ack watchdog enabled by defining MESI_ARB_MEM_TIMEOUT_EN.
module mesi_snoop_bus_arbiter #(
  parameter int N_CACHES       = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [N_CACHES-1:0]   req,
  input  logic [2*N_CACHES-1:0] req_cmd,
  output logic [N_CACHES-1:0]   gnt,
  output logic [N_CACHES-1:0]   done,
  output logic                  c_out,
  output logic                  snoop_valid,
  output logic [1:0]            snoop_cmd,
  output logic [N_CACHES-1:0]   snoop_src,
  input  logic [N_CACHES-1:0]   snoop_shared_in,
  input  logic [N_CACHES-1:0]   snoop_flush_in,
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_RESP,
    S_MEM,
    S_DONE
  } state_t;

  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_UPGR = 2'b11;
  localparam int         PTR_W    = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      win_q, win_d;
  logic [N_CACHES-1:0]   owner_q, owner_d;
  logic [1:0]            cmd_q, cmd_d;
  logic                  c_q, c_d;
  logic [N_CACHES-1:0]   done_q, done_d;
  logic                  c_out_q, c_out_d;
  logic                  valid_q, valid_d;
  logic                  mem_req_q, mem_req_d;

`ifdef MESI_ARB_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  err_q, err_d;
`endif

  logic [N_CACHES-1:0]   elig;
  logic [1:0]            cmd_arr [N_CACHES];
  logic [PTR_W:0]        sum;
  logic [PTR_W-1:0]      pick;
  logic                  found;
  logic                  shared_any;
  logic                  flush_any;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    owner_d   = owner_q;
    cmd_d     = cmd_q;
    c_d       = c_q;
    done_d    = '0;
    c_out_d   = 1'b0;
    valid_d   = 1'b0;
    mem_req_d = 1'b0;
`ifdef MESI_ARB_MEM_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = 1'b0;
`endif

    for (int i = 0; i < N_CACHES; i++) begin
      cmd_arr[i] = req_cmd[2*i +: 2];
      elig[i]    = req[i] & (req_cmd[2*i +: 2] != 2'b00);
    end

    // First eligible index at or after rr_ptr, wrapping past the top.
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int i = 0; i < N_CACHES; i++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N_CACHES)) sum = sum - (PTR_W+1)'(N_CACHES);
      if (!found && elig[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[PTR_W-1:0];
      end
    end

    // The winner never snoops its own request.
    shared_any = |(snoop_shared_in & ~owner_q);
    flush_any  = |(snoop_flush_in & ~owner_q);

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d       = S_GRANT;
          win_d         = pick;
          owner_d       = '0;
          owner_d[pick] = 1'b1;
          cmd_d         = cmd_arr[pick];
          valid_d       = 1'b1;
        end
      end
      S_GRANT: state_d = S_RESP;
      S_RESP: begin
        c_d = shared_any;
        if (cmd_q == CMD_UPGR || flush_any) begin
          state_d = S_DONE;
          done_d  = owner_q;
          c_out_d = shared_any & (cmd_q == CMD_RD);
        end else begin
          state_d   = S_MEM;
          mem_req_d = 1'b1;
`ifdef MESI_ARB_MEM_TIMEOUT_EN
          tmo_d     = '0;
`endif
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d = S_DONE;
          done_d  = owner_q;
          c_out_d = c_q & (cmd_q == CMD_RD);
`ifdef MESI_ARB_MEM_TIMEOUT_EN
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_DONE;
          done_d  = owner_q;
          err_d   = 1'b1;
        end else begin
          tmo_d     = tmo_q + TMO_W'(1);
          mem_req_d = 1'b1;
`else
        end else begin
          mem_req_d = 1'b1;
`endif
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        rr_ptr_d = (win_q == PTR_W'(N_CACHES - 1)) ? '0 : win_q + PTR_W'(1);
        owner_d  = '0;
        cmd_d    = 2'b00;
        c_d      = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      owner_q   <= '0;
      cmd_q     <= 2'b00;
      c_q       <= 1'b0;
      done_q    <= '0;
      c_out_q   <= 1'b0;
      valid_q   <= 1'b0;
      mem_req_q <= 1'b0;
`ifdef MESI_ARB_MEM_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      owner_q   <= owner_d;
      cmd_q     <= cmd_d;
      c_q       <= c_d;
      done_q    <= done_d;
      c_out_q   <= c_out_d;
      valid_q   <= valid_d;
      mem_req_q <= mem_req_d;
`ifdef MESI_ARB_MEM_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  assign gnt         = owner_q;
  assign snoop_src   = owner_q;
  assign snoop_cmd   = cmd_q;
  assign snoop_valid = valid_q;
  assign done        = done_q;
  assign c_out       = c_out_q;
  assign mem_req     = mem_req_q;
`ifdef MESI_ARB_MEM_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_mesi_snoop_bus_arbiter.sv
// Bench for mesi_snoop_bus_arbiter: vector table plus scoreboard of expected completions.
module tb_mesi_snoop_bus_arbiter;

  logic       clk;
  logic       rstb;
  logic [3:0] req;
  logic [7:0] req_cmd;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       c_out;
  logic       snoop_valid;
  logic [1:0] snoop_cmd;
  logic [3:0] snoop_src;
  logic [3:0] snoop_shared_in;
  logic [3:0] snoop_flush_in;
  logic       mem_req;
  logic       mem_ack;
  logic       err;

  mesi_snoop_bus_arbiter #(.N_CACHES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstb(rstb), .req(req), .req_cmd(req_cmd), .gnt(gnt), .done(done),
    .c_out(c_out), .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_src(snoop_src),
    .snoop_shared_in(snoop_shared_in), .snoop_flush_in(snoop_flush_in),
    .mem_req(mem_req), .mem_ack(mem_ack), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] req;
    logic [7:0] cmd;
    logic [3:0] shr;
    logic [3:0] fl;
    int         ack_k;
    logic [3:0] win;
    logic [1:0] wcmd;
    logic       c;
    int         mem_cyc;
    int         lat;
  } vec_t;

  typedef struct {
    logic [3:0] win;
    logic [1:0] cmd;
    logic       c;
    logic       e;
    int         mem_cyc;
    int         lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   t_grant = 0;
  int   mem_cnt = 0;
  int   ack_k = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  task automatic push_exp(input logic [3:0] w, input logic [1:0] c2, input logic c,
                          input logic e, input int m, input int l);
    exp_t x;
    x.win = w; x.cmd = c2; x.c = c; x.e = e; x.mem_cyc = m; x.lat = l;
    sb.push_back(x);
  endtask

  // One clock; observe at the falling edge, answer memory and retire completions.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (snoop_valid) begin
      if (sb.size() == 0) bad("spurious_grant");
      else begin
        chk("snoop_src", snoop_src, sb[0].win);
        chk("snoop_cmd", snoop_cmd, sb[0].cmd);
        chk("gnt_at_grant", gnt, sb[0].win);
      end
      t_grant = cyc;
      mem_cnt = 0;
    end
    if (mem_req) mem_cnt++;
    mem_ack = mem_req && (mem_cnt == ack_k);
    if (done != 4'b0000) begin
      if (sb.size() == 0) bad("spurious_done");
      else begin
        e = sb.pop_front();
        chk("done", done, e.win);
        chk("gnt_at_done", gnt, e.win);
        chk("c_out", c_out, e.c);
        chk("err", err, e.e);
        chk("mem_cycles", mem_cnt, e.mem_cyc);
        chk("latency", cyc - t_grant + 1, e.lat);
        chk("mem_req_at_done", mem_req, 1'b0);
      end
      req = req & ~done;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) begin
      bad("drain_timeout");
      sb.delete();
    end
    repeat (3) tick();
    req = '0;
  endtask

  task automatic run_vec(input vec_t v);
    req             = v.req;
    req_cmd         = v.cmd;
    snoop_shared_in = v.shr;
    snoop_flush_in  = v.fl;
    ack_k           = v.ack_k;
    push_exp(v.win, v.wcmd, v.c, 1'b0, v.mem_cyc, v.lat);
    drain();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb    = 1'b0;
    sb.delete();
    req     = '0;
    mem_ack = 1'b0;
    @(negedge clk);
    rstb    = 1'b1;
  endtask

  initial begin
    //          name        req      cmd    shr      fl       ack win      cmd   c     mem lat
    vecs[0] = '{"rd_mem2",  4'b0100, 8'h10, 4'b0000, 4'b0000, 2, 4'b0100, 2'b01, 1'b0, 2, 5};
    vecs[1] = '{"rd_shr",   4'b0010, 8'h04, 4'b1011, 4'b0000, 1, 4'b0010, 2'b01, 1'b1, 1, 4};
    vecs[2] = '{"rd_own",   4'b0010, 8'h04, 4'b0010, 4'b0000, 3, 4'b0010, 2'b01, 1'b0, 3, 6};
    vecs[3] = '{"rdx_fl",   4'b0001, 8'h02, 4'b0000, 4'b0100, 1, 4'b0001, 2'b10, 1'b0, 0, 3};
    vecs[4] = '{"upgr",     4'b1000, 8'hC0, 4'b0111, 4'b0000, 1, 4'b1000, 2'b11, 1'b0, 0, 3};
    vecs[5] = '{"rd_flshr", 4'b0001, 8'h01, 4'b0010, 4'b0010, 1, 4'b0001, 2'b01, 1'b1, 0, 3};
    vecs[6] = '{"rdx_shr",  4'b0100, 8'h20, 4'b1011, 4'b0000, 1, 4'b0100, 2'b10, 1'b0, 1, 4};
    vecs[7] = '{"cmd00",    4'b0011, 8'h01, 4'b0010, 4'b0000, 1, 4'b0001, 2'b01, 1'b1, 1, 4};
    vecs[8] = '{"own_fl",   4'b1000, 8'h40, 4'b0000, 4'b1000, 1, 4'b1000, 2'b01, 1'b0, 1, 4};

    rstb = 1'b0; req = '0; req_cmd = '0; mem_ack = 1'b0;
    snoop_shared_in = '0; snoop_flush_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {gnt, done, c_out, snoop_valid, snoop_cmd, snoop_src, mem_req, err}, 0);
    rstb = 1'b1;

    run_vec(vecs[0]);

    // Round-robin from rr_ptr=0 with three contenders, then a wrap check.
    do_reset();
    req = 4'b1011; req_cmd = 8'hC9; snoop_shared_in = '0; snoop_flush_in = '0; ack_k = 1;
    push_exp(4'b0001, 2'b01, 1'b0, 1'b0, 1, 4);
    push_exp(4'b0010, 2'b10, 1'b0, 1'b0, 1, 4);
    push_exp(4'b1000, 2'b11, 1'b0, 1'b0, 0, 3);
    drain();
    req = 4'b1001; req_cmd = 8'h41;
    push_exp(4'b0001, 2'b01, 1'b0, 1'b0, 1, 4);
    push_exp(4'b1000, 2'b01, 1'b0, 1'b0, 1, 4);
    drain();

    for (int i = 1; i < 9; i++) run_vec(vecs[i]);

    // Cache 1 alone with cmd 00 must never be granted.
    req = 4'b0010; req_cmd = 8'h00;
    repeat (6) tick();
    chk("cmd00_no_gnt", gnt, 4'b0000);
    req = '0;

    // Asynchronous reset while waiting on memory.
    req = 4'b0100; req_cmd = 8'h10; snoop_shared_in = '0; snoop_flush_in = '0; ack_k = 1000;
    push_exp(4'b0100, 2'b01, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 10 && !mem_req; i++) tick();
    chk("mem_entry", mem_req, 1'b1);
    rstb = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_gnt", gnt, 4'b0000);
    sb.delete();
    req = '0;
    repeat (2) tick();
    ack_k = 1;
    rstb  = 1'b1;
    run_vec(vecs[0]);

`ifdef MESI_ARB_MEM_TIMEOUT_EN
    req = 4'b0100; req_cmd = 8'h10; ack_k = 1000;
    push_exp(4'b0100, 2'b01, 1'b0, 1'b1, 8, 11);
    drain();
    ack_k = 1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
